card_dealer: RTL

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_dealer.sv | 99 +++++++++
 1 files changed

// File: rtl/card_dealer.sv
// Card dealer: a free-running 1..CARD_MAX counter is sampled on each rising
// edge of deal_req and handed to a downstream stage that accepts it with card_ready.
module card_dealer #(
   parameter int unsigned CARD_MAX  = 13,
   parameter int unsigned HAND_SIZE = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       deal_req,
   input  logic       new_hand,
   input  logic       card_ready,
   output logic [3:0] card_out,
   output logic       card_valid,
   output logic [2:0] slot,
   output logic       hand_full
);

   localparam logic [3:0] CMAX  = 4'(CARD_MAX);
   localparam logic [2:0] HSIZE = 3'(HAND_SIZE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t     state, state_n;
   logic [3:0] counter, counter_n;
   logic       prev_req;
   logic       req_edge;
   logic [3:0] card_out_n;
   logic       card_valid_n;
   logic [2:0] slot_n;
   logic       hand_full_n;

   assign req_edge = deal_req & ~prev_req;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         counter    <= 4'd1;
         prev_req   <= 1'b1;
         card_out   <= '0;
         card_valid <= 1'b0;
         slot       <= '0;
         hand_full  <= 1'b0;
      end else begin
         state      <= state_n;
         counter    <= counter_n;
         prev_req   <= deal_req;
         card_out   <= card_out_n;
         card_valid <= card_valid_n;
         slot       <= slot_n;
         hand_full  <= hand_full_n;
      end
   end

   always_comb begin
      state_n      = state;
      card_out_n   = card_out;
      card_valid_n = card_valid;
      slot_n       = slot;
      counter_n    = (counter == CMAX) ? 4'd1 : counter + 4'd1;

      // new_hand beats any coincident deal edge or acceptance
      if (new_hand) begin
         state_n      = IDLE;
         card_out_n   = '0;
         card_valid_n = 1'b0;
         slot_n       = '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_edge) begin
                  card_out_n   = counter;
                  card_valid_n = 1'b1;
                  state_n      = HOLD;
               end
            end
            HOLD: begin
               if (card_ready) begin
                  card_valid_n = 1'b0;
                  slot_n       = slot + 3'd1;
                  state_n      = (slot + 3'd1 == HSIZE) ? FULL : IDLE;
               end
            end
            FULL: begin
               state_n = FULL;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end

      hand_full_n = (slot_n == HSIZE);
   end

endmodule
